// File: rtl/hex_scan_driver_if.sv
// Serial load inputs and decoder-facing scan outputs of hex_scan_driver.
// master drives the serial side, slave is the scan driver itself.
interface hex_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                  ser_data;
    logic                  ser_shift;
    logic                  ser_commit;
    logic [3:0]            nibble;
    logic                  latch;
    logic                  blank;
    logic [NUM_DIGITS-1:0] digit_en;
    logic                  frame_done;

    modport master (
        output ser_data,
        output ser_shift,
        output ser_commit,
        input  nibble,
        input  latch,
        input  blank,
        input  digit_en,
        input  frame_done
    );

    modport slave (
        input  ser_data,
        input  ser_shift,
        input  ser_commit,
        output nibble,
        output latch,
        output blank,
        output digit_en,
        output frame_done
    );
endinterface

// File: rtl/hex_scan_driver.sv
// Serially loaded hex value, scanned across NUM_DIGITS displays with
// blank -> latch -> show sequencing per digit for a 7-segment decoder.
module hex_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 250,
    parameter int BLANK_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    hex_scan_driver_if.slave bus
);
    localparam int W    = 4 * NUM_DIGITS;
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ?
                          DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [1:0] S_BLANK = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHOW  = 2'd2;

    logic [1:0]            r_state;
    logic [IW-1:0]         r_idx;
    logic [CW-1:0]         r_cnt;
    logic [W-1:0]          r_shadow;
    logic [W-1:0]          r_staging;
    logic [W-1:0]          r_display;
    logic                  r_pending;
    logic [3:0]            r_nibble;
    logic                  r_latch;
    logic                  r_blank;
    logic [NUM_DIGITS-1:0] r_digit_en;
    logic                  r_frame_done;

    logic [IW-1:0]         w_idx_inc;
    logic [3:0]            w_next_nib;
    logic [W-1:0]          w_commit_val;
    logic [W-1:0]          w_wrap_disp;
    logic                  w_last_dig;
    logic                  w_blank_done;
    logic                  w_dwell_done;

    assign w_idx_inc    = r_idx + 1'b1;
    assign w_next_nib   = r_display[{w_idx_inc, 2'b00} +: 4];
    assign w_last_dig   = (r_idx == IW'(NUM_DIGITS - 1));
    assign w_blank_done = (r_cnt == CW'(BLANK_CYCLES - 1));
    assign w_dwell_done = (r_cnt == CW'(DWELL_CYCLES - 1));

    // A commit landing in the wrap cycle bypasses staging.
    assign w_commit_val = bus.ser_commit ? r_shadow : r_staging;
    assign w_wrap_disp  = (bus.ser_commit || r_pending) ?
                          w_commit_val : r_display;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_BLANK;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_shadow     <= '0;
            r_staging    <= '0;
            r_display    <= '0;
            r_pending    <= 1'b0;
            r_nibble     <= 4'd0;
            r_latch      <= 1'b0;
            r_blank      <= 1'b1;
            r_digit_en   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (bus.ser_shift) begin
                r_shadow <= {r_shadow[W-2:0], bus.ser_data};
            end
            if (bus.ser_commit) begin
                r_staging <= r_shadow;
                r_pending <= 1'b1;
            end
            unique case (r_state)
                S_BLANK: begin
                    if (w_blank_done) begin
                        r_state <= S_LOAD;
                        r_cnt   <= '0;
                        r_latch <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_LOAD: begin
                    r_state    <= S_SHOW;
                    r_latch    <= 1'b0;
                    r_blank    <= 1'b0;
                    r_digit_en <= NUM_DIGITS'(1) << r_idx;
                end
                S_SHOW: begin
                    if (w_dwell_done) begin
                        r_state    <= S_BLANK;
                        r_cnt      <= '0;
                        r_blank    <= 1'b1;
                        r_digit_en <= '0;
                        if (w_last_dig) begin
                            r_idx        <= '0;
                            r_display    <= w_wrap_disp;
                            r_nibble     <= w_wrap_disp[3:0];
                            r_pending    <= 1'b0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_idx    <= w_idx_inc;
                            r_nibble <= w_next_nib;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_BLANK;
                    r_cnt      <= '0;
                    r_latch    <= 1'b0;
                    r_blank    <= 1'b1;
                    r_digit_en <= '0;
                end
            endcase
        end
    end

    assign bus.nibble     = r_nibble;
    assign bus.latch      = r_latch;
    assign bus.blank      = r_blank;
    assign bus.digit_en   = r_digit_en;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_hex_scan_driver.sv
// Bench for hex_scan_driver: frame-level reference model feeds a latch
// queue; a negedge monitor pops it and checks the scan waveform per cycle.
module tb_hex_scan_driver;
    localparam int ND     = 4;
    localparam int DWELL  = 250;
    localparam int BLNK   = 2;
    localparam int PERIOD = BLNK + 1 + DWELL;
    localparam int FRAME  = ND * PERIOD;

    typedef struct {
        int cyc;
        int nib;
        int dig;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int     cyc   = 0;
    int     tests = 0;
    int     fails = 0;
    int     seen  = 0;
    exp_t   q[$];
    longint m_shadow;
    longint m_stage;
    longint m_disp;
    bit     m_pend;
    longint mask = (longint'(1) << (4 * ND)) - 1;

    hex_scan_driver_if #(.NUM_DIGITS(ND)) bus();

    hex_scan_driver #(
        .NUM_DIGITS  (ND),
        .DWELL_CYCLES(DWELL),
        .BLANK_CYCLES(BLNK)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic void check(string n, longint got, longint want);
        tests++;
        if (got != want) begin
            fails++;
            if (fails < 30)
                $display("FAIL %s: got %0h expected %0h at cyc %0d",
                         n, got, want, cyc);
        end
    endfunction

    // Each frame's digit values are fixed at its start: latch for digit d
    // falls BLNK cycles into that digit's slot.
    function automatic void push_frame(int base, longint val);
        for (int d = 0; d < ND; d++) begin
            q.push_back('{cyc: base + d * PERIOD + BLNK,
                          nib: int'((val >> (4 * d)) & 15),
                          dig: d});
        end
    endfunction

    // Reference model: frame-granular view of shadow/commit/display.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                cyc      = 0;
                m_shadow = 0;
                m_stage  = 0;
                m_disp   = 0;
                m_pend   = 0;
                q.delete();
                push_frame(0, 0);
            end else begin
                cyc++;
                if (bus.ser_commit) begin
                    m_stage = m_shadow;
                    m_pend  = 1;
                end
                if (bus.ser_shift)
                    m_shadow = ((m_shadow << 1) | longint'(bus.ser_data)) & mask;
                if (cyc % FRAME == 0) begin
                    if (m_pend) m_disp = m_stage;
                    m_pend = 0;
                    push_frame(cyc, m_disp);
                end
            end
        end
    end

    // Monitor
    initial begin
        int   show_start;
        int   cur_dig;
        int   cur_nib;
        int   h1;
        int   h2;
        int   nib;
        bit   in_show;
        exp_t e;
        show_start = -100000;
        cur_dig = 0;
        cur_nib = 0;
        h1 = -1;
        h2 = -1;
        forever begin
            @(negedge clk);
            if (reset) begin
                show_start = -100000;
                h1 = -1;
                h2 = -1;
            end else begin
                nib = int'(bus.nibble);
                if (cyc == 0) begin
                    check("rst_nibble", nib, 0);
                    check("rst_blank", bus.blank, 1);
                    check("rst_digit_en", bus.digit_en, 0);
                    check("rst_latch", bus.latch, 0);
                    check("rst_frame_done", bus.frame_done, 0);
                end
                if (bus.latch) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL latch_unexpected: got 1 expected 0 at cyc %0d", cyc);
                    end else begin
                        e = q.pop_front();
                        seen++;
                        check("latch_cycle", cyc, e.cyc);
                        check("latch_nibble", nib, e.nib);
                        check("nibble_setup1", h1, nib);
                        check("nibble_setup2", h2, nib);
                        show_start = cyc + 1;
                        cur_dig = e.dig;
                        cur_nib = e.nib;
                    end
                end else if (q.size() > 0 && q[0].cyc == cyc) begin
                    tests++;
                    fails++;
                    $display("FAIL latch_missing: got 0 expected 1 at cyc %0d", cyc);
                    e = q.pop_front();
                end
                in_show = (cyc >= show_start) && (cyc < show_start + DWELL);
                check("digit_en", bus.digit_en,
                      in_show ? (longint'(1) << cur_dig) : 0);
                check("blank", bus.blank, !in_show);
                check("onehot", ($countones(bus.digit_en) > 1), 0);
                if (in_show) check("show_nibble", nib, cur_nib);
                check("frame_done", bus.frame_done,
                      (cyc > 0) && (cyc % FRAME == 0));
                h2 = h1;
                h1 = nib;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic shift_bit(input logic b);
        bus.ser_shift = 1'b1;
        bus.ser_data  = b;
        tick();
        bus.ser_shift = 1'b0;
        bus.ser_data  = 1'b0;
    endtask

    task automatic load16(input logic [15:0] v);
        for (int i = 15; i >= 0; i--) shift_bit(v[i]);
    endtask

    task automatic commit();
        bus.ser_commit = 1'b1;
        tick();
        bus.ser_commit = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        int n;
        n = 0;
        while (cyc < t) begin
            if (n > 3 * FRAME) begin
                tests++;
                fails++;
                $display("FAIL wait_timeout: got cyc %0d expected %0d", cyc, t);
                break;
            end
            n++;
            tick();
        end
    endtask

    initial begin
        bus.ser_data   = 1'b0;
        bus.ser_shift  = 1'b0;
        bus.ser_commit = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        load16(16'hBEEF);
        commit();

        // commit together with a shift: the new bit must not be displayed
        wait_cyc(FRAME + 50);
        load16(16'hA5C3);
        bus.ser_shift  = 1'b1;
        bus.ser_data   = 1'b1;
        bus.ser_commit = 1'b1;
        tick();
        bus.ser_shift  = 1'b0;
        bus.ser_data   = 1'b0;
        bus.ser_commit = 1'b0;

        // commit sampled on the wrap edge
        wait_cyc(2 * FRAME + 50);
        load16(16'h7E81);
        wait_cyc(3 * FRAME - 1);
        commit();

        // last commit within a frame wins
        wait_cyc(3 * FRAME + 50);
        load16(16'h1234);
        commit();
        load16(16'h5678);
        commit();

        // reset during digit 2 SHOW with a commit pending
        wait_cyc(4 * FRAME + 50);
        load16(16'h9999);
        commit();
        wait_cyc(4 * FRAME + 2 * PERIOD + 100);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        wait_cyc(FRAME + 300);

        for (int i = 0; i < 10 * FRAME; i++) begin
            bus.ser_shift  = ($urandom_range(0, 3) == 0);
            bus.ser_data   = 1'($urandom_range(0, 1));
            bus.ser_commit = ($urandom_range(0, 299) == 0);
            tick();
        end
        bus.ser_shift  = 1'b0;
        bus.ser_data   = 1'b0;
        bus.ser_commit = 1'b0;
        repeat (FRAME + 10) tick();

        check("latch_count", (seen >= 14 * ND), 1);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
